// File: rtl/interrupt_source_unit_pkg.sv
// Shared definitions for the interrupt source unit: default line count and
// write-port register select encoding.
package interrupt_source_unit_pkg;

  localparam int unsigned INT_WIDTH = 8;

  typedef enum logic {
    WR_SEL_MASK   = 1'b0,
    WR_SEL_PERIOD = 1'b1
  } wr_sel_e;

endpackage

// File: rtl/interrupt_source_unit_sync_edge.sv
// Vector two-flop synchroniser followed by a rising-edge detector; one
// single-cycle pulse per observed low-to-high transition of each line.
module sync_edge
  import interrupt_source_unit_pkg::*;
#(
  parameter int unsigned WIDTH = INT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_source_unit.sv
// Interrupt front end: synchronised pin edges plus a periodic timer tick,
// masked and registered into single-cycle request pulses on int_e.
module interrupt_source_unit
  import interrupt_source_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = INT_WIDTH,
  parameter int unsigned TIMER_BITS = 16,
  parameter int unsigned TIMER_LINE = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      irq_pin,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [TIMER_BITS-1:0] wr_data,
  output logic [WIDTH-1:0]      int_e,
  output logic [WIDTH-1:0]      mask_q,
  output logic [TIMER_BITS-1:0] timer_cnt
);

  logic [WIDTH-1:0]      edge_vec;
  logic [WIDTH-1:0]      tick_vec;
  logic [WIDTH-1:0]      mask_d;
  logic [WIDTH-1:0]      int_e_q, int_e_d;
  logic [TIMER_BITS-1:0] period_q, period_d;
  logic [TIMER_BITS-1:0] cnt_q, cnt_d;
  logic                  tick;
  logic                  mask_wr;
  logic                  period_wr;
  wr_sel_e               sel;

  sync_edge #(
    .WIDTH (WIDTH)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_i (irq_pin),
    .rise_o  (edge_vec)
  );

  assign sel       = wr_sel_e'(wr_sel);
  assign mask_wr   = wr_en && (sel == WR_SEL_MASK);
  assign period_wr = wr_en && (sel == WR_SEL_PERIOD);

  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    tick     = 1'b0;
    tick_vec = '0;

    if (mask_wr) begin
      mask_d = wr_data[WIDTH-1:0];
    end

    // A period write reloads the counter and suppresses that cycle's tick.
    if (period_wr) begin
      period_d = wr_data;
      cnt_d    = (wr_data == '0) ? '0 : wr_data - TIMER_BITS'(1);
    end else if (period_q != '0) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = period_q - TIMER_BITS'(1);
      end else begin
        cnt_d = cnt_q - TIMER_BITS'(1);
      end
    end else begin
      cnt_d = '0;
    end

    tick_vec[TIMER_LINE] = tick;
    // Masking uses the current mask, so a write takes effect one edge later.
    int_e_d = (edge_vec | tick_vec) & mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      int_e_q  <= '0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      int_e_q  <= int_e_d;
    end
  end

  assign int_e     = int_e_q;
  assign timer_cnt = cnt_q;

endmodule
